// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA pixel timebase running entirely in the clk domain.
// A clock-enable style pixel strobe (one step every CLK_DIV clocks) walks
// horizontal/vertical counters through active, front porch, sync and back
// porch, producing registered sync, active-video and pixel coordinates.
//
// Optional feature macro: VGA_FRAME_PULSE_EN
//   defined   -> frame_start pulses with pix_en at pixel (0,0) once per frame
//   undefined -> frame_start is tied low (port kept for a stable interface)
module vga_timing_ctrl #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned H_W     = $clog2(H_TOTAL);
    localparam int unsigned V_W     = $clog2(V_TOTAL);
    localparam int unsigned XY_W    = 10;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);

    // Phase boundaries: first count value of each phase after ACTIVE.
    localparam logic [H_W-1:0] H_FP_START   = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] H_SYNC_START = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] H_BP_START   = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0] V_FP_START   = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] V_SYNC_START = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] V_BP_START   = V_W'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

    // Classify a horizontal count into its line phase.
    function automatic phase_t h_phase(input logic [H_W-1:0] h);
        phase_t ph;
        if (h < H_FP_START)        ph = PH_ACTIVE;
        else if (h < H_SYNC_START) ph = PH_FRONT;
        else if (h < H_BP_START)   ph = PH_SYNC;
        else                       ph = PH_BACK;
        return ph;
    endfunction

    // Classify a vertical count into its frame phase.
    function automatic phase_t v_phase(input logic [V_W-1:0] v);
        phase_t ph;
        if (v < V_FP_START)        ph = PH_ACTIVE;
        else if (v < V_SYNC_START) ph = PH_FRONT;
        else if (v < V_BP_START)   ph = PH_SYNC;
        else                       ph = PH_BACK;
        return ph;
    endfunction

    logic [DIV_W-1:0] div_cnt;
    logic [H_W-1:0]   h_cnt;
    logic [V_W-1:0]   v_cnt;

    logic             step_c;
    logic             h_wrap_c;
    logic [DIV_W-1:0] div_nxt_c;
    logic [H_W-1:0]   h_nxt_c;
    logic [V_W-1:0]   v_nxt_c;
    phase_t           h_ph_c;
    phase_t           v_ph_c;
    logic             active_nxt_c;

    // Step detection and next counter values; counters only move on a step.
    always_comb begin
        step_c       = 1'b0;
        h_wrap_c     = 1'b0;
        div_nxt_c    = div_cnt;
        h_nxt_c      = h_cnt;
        v_nxt_c      = v_cnt;

        if (en) begin
            if (div_cnt == DIV_LAST) begin
                step_c    = 1'b1;
                div_nxt_c = '0;
            end else begin
                div_nxt_c = div_cnt + DIV_W'(1);
            end
        end

        if (step_c) begin
            h_wrap_c = (h_cnt == H_LAST);
            h_nxt_c  = h_wrap_c ? '0 : (h_cnt + H_W'(1));
            if (h_wrap_c) begin
                v_nxt_c = (v_cnt == V_LAST) ? '0 : (v_cnt + V_W'(1));
            end
        end

        h_ph_c       = h_phase(h_nxt_c);
        v_ph_c       = v_phase(v_nxt_c);
        active_nxt_c = (h_ph_c == PH_ACTIVE) && (v_ph_c == PH_ACTIVE);
    end

    // Divider and raster counters; reset parks them one step before (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            h_cnt   <= H_LAST;
            v_cnt   <= V_LAST;
        end else begin
            div_cnt <= div_nxt_c;
            h_cnt   <= h_nxt_c;
            v_cnt   <= v_nxt_c;
        end
    end

    // Registered timing outputs, refreshed on the step edge from the new counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_en <= 1'b0;
            hsync  <= ~SYNC_POL;
            vsync  <= ~SYNC_POL;
            active <= 1'b0;
            x      <= '0;
            y      <= '0;
        end else if (step_c) begin
            pix_en <= 1'b1;
            hsync  <= (h_ph_c == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            vsync  <= (v_ph_c == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            active <= active_nxt_c;
            x      <= active_nxt_c ? XY_W'(h_nxt_c) : '0;
            y      <= active_nxt_c ? XY_W'(v_nxt_c) : '0;
        end else begin
            pix_en <= 1'b0;
        end
    end

`ifdef VGA_FRAME_PULSE_EN
    // Frame marker: rides along with the pix_en cycle that presents (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= step_c && (h_nxt_c == '0) && (v_nxt_c == '0);
        end
    end
`else
    assign frame_start = 1'b0;
`endif

endmodule
